// File: rtl/display_scan_ctrl.sv
// Multiplexed 4-digit hex display scanner with guard gaps,
// leading-zero blanking and frame-synchronous (tear-free) value updates.
module display_scan_ctrl #(
  parameter int DIV   = 100000,
  parameter int GUARD = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  input  logic [15:0] value,
  input  logic        load,
  input  logic        lz_en,
  input  logic [3:0]  dp_in,
  output logic [3:0]  an,
  output logic [3:0]  hex,
  output logic        blank,
  output logic        dp,
  output logic        frame_done
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] G_END = CW'(GUARD - 1);
  localparam logic [CW-1:0] S_END = CW'(DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GUARD,
    S_ON
  } st_t;

  st_t         st, st_n;
  logic [1:0]  d, d_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [15:0] disp, stage;
  logic        pend, fd;
  logic        bnd;
  logic [15:0] hi;
  logic        supp;

  // cnt spans the whole slot; the guard is its first GUARD counts
  assign bnd = en && (st == S_ON) && (d == 2'd3) && (cnt == S_END);

  always_comb begin
    st_n  = st;
    d_n   = d;
    cnt_n = cnt;
    if (!en) begin
      st_n  = S_IDLE;
      d_n   = '0;
      cnt_n = '0;
    end else begin
      unique case (st)
        S_IDLE: begin
          st_n  = S_GUARD;
          d_n   = '0;
          cnt_n = '0;
        end
        S_GUARD: begin
          cnt_n = cnt + CW'(1);
          if (cnt == G_END) st_n = S_ON;
        end
        S_ON: begin
          if (cnt == S_END) begin
            st_n  = S_GUARD;
            cnt_n = '0;
            d_n   = d + 2'd1;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        default: st_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st    <= S_IDLE;
      d     <= '0;
      cnt   <= '0;
      fd    <= 1'b0;
      disp  <= '0;
      stage <= '0;
      pend  <= 1'b0;
    end else begin
      st  <= st_n;
      d   <= d_n;
      cnt <= cnt_n;
      fd  <= bnd;
      if (bnd) begin
        if (load)      disp <= value;
        else if (pend) disp <= stage;
        pend <= 1'b0;
      end else if (load) begin
        stage <= value;
        pend  <= 1'b1;
      end
    end
  end

  assign hi   = disp >> {d, 2'b00};
  assign supp = lz_en && (d != 2'd0) && (hi == 16'h0000);

  always_comb begin
    an    = 4'b1111;
    blank = 1'b1;
    dp    = 1'b1;
    hex   = hi[3:0];
    if (st == S_ON && !supp) begin
      an    = ~(4'b0001 << d);
      blank = 1'b0;
      dp    = ~dp_in[d];
    end
  end

  assign frame_done = fd;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Randomized bench for display_scan_ctrl against a time-based
// reference model (slot and phase derived from cycles since enable).
module tb_display_scan_ctrl;

  localparam int DIV   = 8;
  localparam int GUARD = 2;
  localparam int FRM   = 4 * DIV;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        en = 1'b0;
  logic [15:0] value = '0;
  logic        load = 1'b0;
  logic        lz_en = 1'b0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  an;
  logic [3:0]  hex;
  logic        blank;
  logic        dp;
  logic        frame_done;

  int total = 0;
  int bad = 0;

  // reference model state
  logic        m_on = 1'b0;
  int          t = 0;
  logic [15:0] m_disp = '0;
  logic [15:0] m_stage = '0;
  logic        m_pend = 1'b0;
  logic        m_fd = 1'b0;

  display_scan_ctrl #(.DIV(DIV), .GUARD(GUARD)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .en(en),
    .value(value),
    .load(load),
    .lz_en(lz_en),
    .dp_in(dp_in),
    .an(an),
    .hex(hex),
    .blank(blank),
    .dp(dp),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_on = 1'b0; t = 0; m_disp = '0;
    m_stage = '0; m_pend = 1'b0; m_fd = 1'b0;
  endtask

  task automatic model_step();
    logic b;
    b = m_on && en && (t % FRM == FRM - 1);
    m_fd = b;
    if (b) begin
      if (load) m_disp = value;
      else if (m_pend) m_disp = m_stage;
      m_pend = 1'b0;
    end else if (load) begin
      m_stage = value;
      m_pend = 1'b1;
    end
    if (!en) begin
      m_on = 1'b0; t = 0;
    end else if (!m_on) begin
      m_on = 1'b1; t = 0;
    end else begin
      t = (t + 1) % FRM;
    end
  endtask

  task automatic cmp_outputs();
    int k;
    logic [15:0] h;
    logic [3:0] e_an, e_hex;
    logic e_bl, e_dp, lit;
    k = m_on ? (t / DIV) : 0;
    h = m_disp >> (4 * k);
    e_hex = h[3:0];
    lit = m_on && (t % DIV >= GUARD) && !(lz_en && k > 0 && h == 0);
    e_an = lit ? ~(4'b0001 << k) : 4'b1111;
    e_bl = !lit;
    e_dp = lit ? ~dp_in[k] : 1'b1;
    chk("an", 16'(an), 16'(e_an));
    chk("hex", 16'(hex), 16'(e_hex));
    chk("blank", 16'(blank), 16'(e_bl));
    chk("dp", 16'(dp), 16'(e_dp));
    chk("frame_done", 16'(frame_done), 16'(m_fd && m_on));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cmp_outputs();
  endtask

  initial begin
    logic [15:0] masks [5];
    bit found;
    masks = '{16'hFFFF, 16'h0FFF, 16'h00FF, 16'h000F, 16'h0000};
    model_reset();
    #12;
    chk("rst_an", 16'(an), 16'hF);
    chk("rst_hex", 16'(hex), 16'h0);
    chk("rst_blank", 16'(blank), 16'h1);
    chk("rst_dp", 16'(dp), 16'h1);
    chk("rst_fd", 16'(frame_done), 16'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // scan sequence: 1234 staged while idle, shown from 2nd frame
    load = 1'b1; value = 16'h1234;
    cycle();
    load = 1'b0; en = 1'b1;
    for (int i = 0; i < 2 * FRM + 2; i++) cycle();

    // leading zeros and decimal point
    lz_en = 1'b1; dp_in = 4'b0100;
    load = 1'b1; value = 16'h0070;
    cycle();
    load = 1'b0;
    for (int i = 0; i < 2 * FRM; i++) cycle();
    load = 1'b1; value = 16'h0000;
    cycle();
    load = 1'b0;
    for (int i = 0; i < 2 * FRM; i++) cycle();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if (en) begin
        if ($urandom % 90 == 0) en = 1'b0;
      end else if ($urandom % 6 == 0) begin
        en = 1'b1;
      end
      load = ($urandom % 25 == 0);
      value = 16'($urandom) & masks[$urandom % 5];
      if ($urandom % 150 == 0) lz_en = ~lz_en;
      if ($urandom % 10 == 0) dp_in = 4'($urandom);
      cycle();
    end

    // load coincident with a frame boundary
    en = 1'b1; load = 1'b0; lz_en = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (m_on && t % FRM == FRM - 1) found = 1'b1;
      else cycle();
    end
    chk("bnd_timeout", 16'(found), 16'h1);
    load = 1'b1; value = 16'h5A5A;
    cycle();
    load = 1'b0;
    cycle();
    cycle();
    chk("coinc_hex", 16'(hex), 16'hA);
    chk("coinc_an", 16'(an), 16'hE);
    for (int i = 0; i < 5; i++) cycle();

    // async reset between edges, mid-slot
    #2 reset_n = 1'b0;
    #1;
    chk("arst_an", 16'(an), 16'hF);
    chk("arst_blank", 16'(blank), 16'h1);
    chk("arst_hex", 16'(hex), 16'h0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < FRM + 4; i++) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
